// File: rtl/dmem_ctrl_pkg.sv
// Shared types and defaults for the MEM-stage data memory sequencer.
// Pulled in by the FSM top and its timeout counter.
package dmem_ctrl_pkg;

    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIMEOUT = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter width that can hold TIMEOUT-1, never narrower than one bit.
    function automatic int cnt_width(input int timeout);
        return (timeout > 2) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/dmem_timeout_cnt.sv
// Clear/enable cycle counter that flags the last REQ cycle allowed before
// the sequencer gives up on the memory.
module dmem_timeout_cnt
    import dmem_ctrl_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = cnt_width(TIMEOUT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Counter holds (REQ cycles elapsed - 1), so this marks the TIMEOUT-th cycle.
    assign expired_o = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage sequencer: turns MemRead/MemWrite into a req/ack transaction,
// stalls the pipeline until completion and returns load data.
//
// Memory handshake: mem_req_o is held high with address, data and we stable
// from the first REQ cycle until the cycle in which mem_ack_i pulses (or the
// timeout fires); mem_ack_i is only honoured while mem_req_o is high, and
// mem_rdata_i is sampled in that same cycle.
module dmem_access_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              stall_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rdata_valid_o,
    output logic              err_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [1:0]        dbg_state_o
);

    state_t state_q;
    state_t state_d;

    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              we_q;
    logic              err_q;

    logic stall;
    logic mem_req;
    logic capture;
    logic latch_rdata;
    logic timeout;
    logic cnt_clr;
    logic cnt_en;
    logic expired;

    dmem_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_cnt (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (cnt_clr),
        .en_i      (cnt_en),
        .expired_o (expired)
    );

    always_comb begin
        state_d     = state_q;
        stall       = 1'b0;
        mem_req     = 1'b0;
        capture     = 1'b0;
        latch_rdata = 1'b0;
        timeout     = 1'b0;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Stall is Mealy here so the pipeline freezes in the detect cycle.
                if (MemRead_i || MemWrite_i) begin
                    stall   = 1'b1;
                    capture = 1'b1;
                    cnt_clr = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                stall   = 1'b1;
                mem_req = 1'b1;
                if (mem_ack_i) begin
                    latch_rdata = ~we_q;
                    state_d     = ST_DONE;
                end else if (expired) begin
                    timeout = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_DONE: begin
                // Inputs still show the finished instruction; ignore them.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
                we_q    <= MemWrite_i & ~MemRead_i;
            end
            if (latch_rdata) begin
                rdata_q <= mem_rdata_i;
            end else if (timeout) begin
                rdata_q <= '0;
            end
            if (timeout) begin
                err_q <= 1'b1;
            end
        end
    end

    assign stall_o       = stall;
    assign mem_req_o     = mem_req;
    assign mem_we_o      = we_q;
    assign mem_addr_o    = addr_q;
    assign mem_wdata_o   = wdata_q;
    assign rdata_o       = rdata_q;
    assign rdata_valid_o = (state_q == ST_DONE) && !we_q;
    assign err_o         = err_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: directed cases from the plan plus random
// loads/stores against a transaction-level reference model.
module tb_dmem_access_ctrl;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_i = 1'b0;
  logic          MemRead_i = 1'b0;
  logic          MemWrite_i = 1'b0;
  logic [AW-1:0] addr_i = '0;
  logic [DW-1:0] wdata_i = '0;
  logic          stall_o;
  logic [DW-1:0] rdata_o;
  logic          rdata_valid_o;
  logic          err_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mem_ack_i = 1'b0;
  logic [DW-1:0] mem_rdata_i = '0;
  logic [1:0]    dbg_state_o;

  dmem_access_ctrl #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TO)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .MemRead_i     (MemRead_i),
    .MemWrite_i    (MemWrite_i),
    .addr_i        (addr_i),
    .wdata_i       (wdata_i),
    .stall_o       (stall_o),
    .rdata_o       (rdata_o),
    .rdata_valid_o (rdata_valid_o),
    .err_o         (err_o),
    .mem_req_o     (mem_req_o),
    .mem_we_o      (mem_we_o),
    .mem_addr_o    (mem_addr_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_ack_i     (mem_ack_i),
    .mem_rdata_i   (mem_rdata_i),
    .dbg_state_o   (dbg_state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          err;
    int            req_cycles;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // reference model state
  logic [DW-1:0] last_rdata_m = '0;
  logic          err_m = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_stall"}, stall_o, 0);
    check({tag, "_req"}, mem_req_o, 0);
    check({tag, "_we"}, mem_we_o, 0);
    check({tag, "_addr"}, mem_addr_o, 0);
    check({tag, "_wdata"}, mem_wdata_o, 0);
    check({tag, "_rdata"}, rdata_o, 0);
    check({tag, "_valid"}, rdata_valid_o, 0);
    check({tag, "_err"}, err_o, 0);
  endtask

  // driver: called at posedge+1 with the controller idle; returns at posedge+1
  // after the completion cycle. ack_n = REQ cycle carrying the ack, 0 = never.
  task automatic do_op(input logic rd, input logic wr, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, input int ack_n, input logic [DW-1:0] rdata);
    exp_t e;
    int   req_n;
    MemRead_i  = rd;
    MemWrite_i = wr;
    addr_i     = addr;
    wdata_i    = wdata;
    e.we    = wr & ~rd;
    e.addr  = addr;
    e.wdata = wdata;
    if (ack_n >= 1 && ack_n <= TO) begin
      req_n = ack_n;
      if (!e.we) last_rdata_m = rdata;
    end else begin
      req_n        = TO;
      last_rdata_m = '0;
      err_m        = 1'b1;
    end
    e.rdata      = last_rdata_m;
    e.err        = err_m;
    e.req_cycles = req_n;
    exp_q.push_back(e);
    @(posedge clk); #1;
    for (int k = 1; k <= req_n; k++) begin
      addr_i      = $urandom;
      wdata_i     = $urandom;
      mem_ack_i   = (k == ack_n);
      mem_rdata_i = (k == ack_n) ? rdata : $urandom;
      @(posedge clk); #1;
    end
    mem_ack_i   = 1'b0;
    mem_rdata_i = $urandom;
    @(posedge clk); #1;
    MemRead_i  = 1'b0;
    MemWrite_i = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // monitor / scoreboard
  int   req_cnt = 0;
  int   stall_cnt = 0;
  logic prev_req = 1'b0;
  logic prev_done = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_i) begin
      req_cnt   = 0;
      stall_cnt = 0;
      prev_req  = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (prev_done) check("no_reissue", mem_req_o, 0);
      prev_done = 1'b0;
      if (stall_o) stall_cnt++;
      if (mem_req_o) begin
        req_cnt++;
        if (exp_q.size() > 0) begin
          check("req_addr", mem_addr_o, exp_q[0].addr);
          check("req_wdata", mem_wdata_o, exp_q[0].wdata);
          check("req_we", mem_we_o, exp_q[0].we);
        end
      end else if (prev_req) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("done_stall", stall_o, 0);
          check("done_valid", rdata_valid_o, !e.we);
          check("done_rdata", rdata_o, e.rdata);
          check("done_err", err_o, e.err);
          check("req_cycles", req_cnt, e.req_cycles);
          check("stall_cycles", stall_cnt, e.req_cycles + 1);
        end
        req_cnt   = 0;
        stall_cnt = 0;
        prev_done = 1'b1;
      end
      prev_req = mem_req_o;
    end
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    logic rd;
    logic wr;
    int   ack_n;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst_i = 1'b1;
    idle(2);

    // load, zero-wait
    do_op(1'b1, 1'b0, 32'h100, 32'h0, 1, 32'hDEADBEEF);
    idle(1);
    // store, ack in 5th REQ cycle
    do_op(1'b0, 1'b1, 32'h20, 32'h12345678, 5, 32'h0);
    idle(1);
    // both controls high -> read
    do_op(1'b1, 1'b1, 32'h44, 32'hAAAA5555, 2, 32'hCAFEF00D);
    idle(1);
    // spurious ack while idle
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'h0BADF00D;
    @(posedge clk); #1;
    mem_ack_i = 1'b0;
    check("spur_req", mem_req_o, 0);
    check("spur_stall", stall_o, 0);
    check("spur_valid", rdata_valid_o, 0);
    check("spur_rdata", rdata_o, last_rdata_m);
    idle(1);
    // load then store back to back
    do_op(1'b1, 1'b0, 32'h200, 32'h0, 1, 32'h11223344);
    do_op(1'b0, 1'b1, 32'h204, 32'h55667788, 1, 32'h0);
    // ack on the last allowed cycle is still a completion
    do_op(1'b1, 1'b0, 32'h300, 32'h0, TO, 32'h76543210);
    idle(1);
    // no ack -> timeout
    do_op(1'b1, 1'b0, 32'h400, 32'h0, 0, 32'h0);
    idle(2);
    check("err_sticky", err_o, 1);
    check("rdata_cleared", rdata_o, 0);

    // reset in REQ cycle 3
    MemRead_i = 1'b1;
    addr_i    = 32'h500;
    idle(3);
    rst_i     = 1'b0;
    MemRead_i = 1'b0;
    #1;
    check_reset_vals("midreset");
    err_m        = 1'b0;
    last_rdata_m = '0;
    @(posedge clk); #1;
    rst_i = 1'b1;
    idle(1);
    do_op(1'b1, 1'b0, 32'h600, 32'h0, 3, 32'h0F0F0F0F);
    idle(1);

    // random traffic
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 2))
        0: begin rd = 1'b1; wr = 1'b0; end
        1: begin rd = 1'b0; wr = 1'b1; end
        default: begin rd = 1'b1; wr = 1'b1; end
      endcase
      ack_n = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, TO + 1);
      do_op(rd, wr, $urandom, $urandom, ack_n, $urandom);
      idle($urandom_range(0, 2));
    end

    idle(3);
    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Sequencer between the pipeline's MEM stage and a variable-latency data memory. It converts the MemRead/MemWrite controls issued by the main decoder into a req/ack memory transaction, stalls the pipeline until the transaction completes, and returns load data. A timeout guards against a memory that never acknowledges.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 64, max REQ cycles without ack before abort (≥2)

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset; asynchronous, active-low
- MemRead_i  in  1  load in MEM stage
- MemWrite_i  in  1  store in MEM stage
- addr_i  in  ADDR_W  ALU result (effective address)
- wdata_i  in  DATA_W  store data
- stall_o  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- rdata_o  out  DATA_W  load data to MEM/WB
- rdata_valid_o  out  1  rdata_o valid this cycle
- err_o  out  1  sticky timeout flag
- mem_req_o  out  1  request to memory
- mem_we_o  out  1  1 = write
- mem_addr_o  out  ADDR_W  registered address
- mem_wdata_o  out  DATA_W  registered write data
- mem_ack_i  in  1  memory completion, one-cycle pulse
- mem_rdata_i  in  DATA_W  read data, valid with mem_ack_i

## Operation
- States: IDLE, REQ, DONE.
- IDLE: if MemRead_i|MemWrite_i → capture addr_i, wdata_i, we = MemWrite_i & ~MemRead_i into mem_* regs; clear timeout counter; next REQ. Otherwise stay.
- Both MemRead_i and MemWrite_i high: treated as read (read priority); no other effect.
- REQ: mem_req_o=1, address/data/we held stable. mem_ack_i=1 → if read, latch mem_rdata_i into rdata_o; next DONE. Else counter increments; counter reaching TIMEOUT-1 without ack → err_o set, rdata_o=0, next DONE (transaction abandoned).
- DONE: stall_o=0, rdata_valid_o=1 (reads only; 0 for writes); pipeline advances. Inputs ignored this cycle so the same instruction is never reissued. Next IDLE unconditionally.
- stall_o = (IDLE & (MemRead_i|MemWrite_i)) | REQ — Mealy in IDLE, registered-state in REQ.
- mem_ack_i outside REQ ignored.
- err_o sticky; cleared only by reset.
- rdata_o holds last value except at timeout (cleared to 0).

## Timing
- Reset (rst_i=0, async): state IDLE, stall_o=0 (with no request), mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, rdata_o=0, rdata_valid_o=0, err_o=0, counter=0. Reset mid-REQ drops mem_req_o immediately; no completion reported.
- Zero-wait memory (ack in first REQ cycle): cycle0 IDLE stall=1; cycle1 REQ req=1, ack; cycle2 DONE stall=0, rdata_valid=1. Stall = 2 cycles; stall = N+1 for ack in Nth REQ cycle.
- Back-to-back memory ops: next op detected in IDLE the cycle after DONE; minimum 3 cycles per op.
- Timeout: req high for exactly TIMEOUT cycles, DONE follows.

## Structure
- Package dmem_ctrl_pkg: state enum (IDLE, REQ, DONE), default TIMEOUT, DATA_W/ADDR_W constants.
- Sub-module dmem_timeout_cnt: clear/enable counter of width $clog2(TIMEOUT), output expired; rest in one FSM module.

## Test plan
- Load, addr_i=0x100, ack in first REQ cycle with mem_rdata_i=0xDEADBEEF → stall_o high 2 cycles, mem_we_o=0, rdata_o=0xDEADBEEF with rdata_valid_o=1 in DONE.
- Store, addr_i=0x20, wdata_i=0x12345678, ack after 5 REQ cycles → mem_we_o=1, mem_addr_o/mem_wdata_o stable all 5 cycles, stall 6 cycles, rdata_valid_o=0.
- No ack, TIMEOUT=8 → mem_req_o high exactly 8 cycles, err_o=1 and stays 1, rdata_o=0, pipeline released.
- Load then store on consecutive instructions, ack immediate → two separate transactions, each op's DONE followed by IDLE, no duplicate requests.
- MemRead_i=MemWrite_i=1 → read transaction (mem_we_o=0); spurious mem_ack_i in IDLE → no state change.
- rst_i low during REQ cycle 3 → mem_req_o=0 same cycle, all outputs at reset values, later load completes normally.
